// File: rtl/math_bin2bcd_seq.sv
// Sequential 9-bit binary to three-digit BCD converter (double-dabble, one bit per clock).
// Optional macro BCD_BLANK_LEADING_EN blanks leading zero digits to 4'hF on load and reset.
module math_bin2bcd_seq #(
    parameter int IN_WIDTH = 9
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [IN_WIDTH-1:0] i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [3:0]          o_bcd_hund,
    output logic [3:0]          o_bcd_tens,
    output logic [3:0]          o_bcd_ones,
    output logic [1:0]          o_dbg_state
);

    // Handshake: i_start is taken only in IDLE, where i_bin is captured on that same edge.
    // o_busy covers SHIFT and DONE; o_done pulses for one cycle as the digits update.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

`ifdef BCD_BLANK_LEADING_EN
    localparam logic [3:0] RST_LEAD = 4'hF;
`else
    localparam logic [3:0] RST_LEAD = 4'h0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_WIDTH-1:0] r_shift;
    logic [11:0]         r_scratch;
    logic [3:0]          r_cnt;
    logic [3:0]          r_hund;
    logic [3:0]          r_tens;
    logic [3:0]          r_ones;

    logic [11:0]         w_adj;
    logic [11:0]         w_scr_nxt;
    logic                w_last;
    logic [3:0]          w_hund_ld;
    logic [3:0]          w_tens_ld;

    // Add-3 correction per nibble; a nibble of at most 9 never carries out.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_scr_nxt = {w_adj[10:0], r_shift[IN_WIDTH-1]};
    assign w_last    = (r_cnt == 4'd1);

`ifdef BCD_BLANK_LEADING_EN
    assign w_hund_ld = (w_scr_nxt[11:8] == 4'd0) ? 4'hF : w_scr_nxt[11:8];
    assign w_tens_ld = (w_scr_nxt[11:4] == 8'd0) ? 4'hF : w_scr_nxt[7:4];
`else
    assign w_hund_ld = w_scr_nxt[11:8];
    assign w_tens_ld = w_scr_nxt[7:4];
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_hund    <= RST_LEAD;
            r_tens    <= RST_LEAD;
            r_ones    <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift   <= i_bin;
                        r_scratch <= '0;
                        r_cnt     <= 4'(IN_WIDTH);
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scr_nxt;
                    r_shift   <= {r_shift[IN_WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_hund <= w_hund_ld;
                        r_tens <= w_tens_ld;
                        r_ones <= w_scr_nxt[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_bcd_hund  = r_hund;
    assign o_bcd_tens  = r_tens;
    assign o_bcd_ones  = r_ones;
    assign o_dbg_state = r_state;

endmodule
